// File: rtl/vector_data_memory.sv
// vector_data_memory: word-organised data memory for the vector processor.
// After each reset it zero-fills every word (CLEAR), then services single-cycle
// read/write requests (SERVE). Reads return after READ_LATENCY cycles through
// a valid/data shift pipeline. Misaligned, out-of-range and simultaneous
// read+write requests pulse err for one cycle.
module vector_data_memory #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rden,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  ready,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    clearing;
  logic                    legal;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    bad_req;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Stage i holds a read accepted i edges ago; the last stage drives q/q_valid.
  logic [READ_LATENCY:1]   vld_pipe;
  logic [DATA_WIDTH-1:0]   dat_pipe [READ_LATENCY:1];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  // Next state: leave CLEAR once the last word has been written
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = SERVE;
  end

  // State decode; both come straight off the state flop
  always_comb begin
    ready    = (state == SERVE);
    clearing = (state == CLEAR);
  end

  // Clear pointer, restarts from word 0 on every reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + 1'b1;
  end

  // Request decode; nothing is accepted or flagged while not ready
  always_comb begin
    idx     = address[ADDR_WIDTH+1:2];
    legal   = (address[1:0] == 2'b00) && ((address >> (ADDR_WIDTH + 2)) == 32'd0);
    wr_acc  = ready & wren & legal;
    rd_acc  = ready & rden & ~wren & legal;
    bad_req = ready & (((rden | wren) & ~legal) | (rden & wren));
  end

  // Array write port: zero-fill during CLEAR, accepted writes during SERVE
  always_ff @(posedge clk) begin
    if (clearing)    mem[clr_cnt] <= '0;
    else if (wr_acc) mem[idx]     <= data;
  end

  // Read pipeline; stages only load on a valid so q holds between pulses.
  // Stage 1 samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int i = 1; i <= READ_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= mem[idx];
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  // Error pulse, one cycle after the offending request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= bad_req;
  end

  assign q_valid = vld_pipe[READ_LATENCY];
  assign q       = dat_pipe[READ_LATENCY];

endmodule

// File: tb/tb_vector_data_memory.sv
// Bench for vector_data_memory (ADDR_WIDTH=4, READ_LATENCY=2). The driver
// applies directed and random requests and, from a word-array model, pushes
// the expected read data / err pulses (with their due cycle) into queues; a
// negedge monitor pops and compares whenever the DUT presents an output.
module tb_vector_data_memory;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   address = '0;
  logic [DW-1:0] data = '0;
  logic          rden = 1'b0;
  logic          wren = 1'b0;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          ready;
  logic          err;

  vector_data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .address(address), .data(data),
    .rden(rden), .wren(wren), .q(q), .q_valid(q_valid),
    .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          due;
  } rd_t;

  rd_t         rq[$];
  int          eq[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] q_last = '0;
  int          gcyc = 0;
  int          rel_edge = 0;
  int          vecs = 0;
  int          miss = 0;

  // Global cycle count and edges since reset release (edge 1 = first edge after release)
  always @(posedge clk) begin
    gcyc++;
    if (!rst) rel_edge = 0;
    else      rel_edge++;
  end

  // Apply one request for the next edge and record what it should produce
  task automatic apply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic lg;
    int   ix;
    rd_t  r;
    @(posedge clk); #1;
    rden = rd; wren = wr; address = a; data = d;
    if (rst && rel_edge >= DEPTH && (rd || wr)) begin
      lg = (a % 4 == 0) && (a < DEPTH * 4);
      ix = int'(a / 4) % DEPTH;
      if (!lg || (rd && wr)) eq.push_back(gcyc + 1);
      if (lg && wr) mem_m[ix] = d;
      else if (lg && rd) begin
        r.d = mem_m[ix];
        r.due = gcyc + RL;
        rq.push_back(r);
      end
    end
  endtask

  // Pulse reset for two cycles; everything in flight is forgotten
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; rden = 1'b0; wren = 1'b0;
    rq.delete(); eq.delete();
    q_last = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: ready timing, read data, q hold, err pulses
  always @(negedge clk) begin
    rd_t r;
    int  e;
    logic exp_rdy;
    exp_rdy = rst && (rel_edge >= DEPTH);
    vecs++;
    if (ready !== exp_rdy) begin
      miss++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", gcyc, ready, exp_rdy);
    end
    if (q_valid === 1'b1) begin
      vecs++;
      if (rq.size() == 0) begin
        miss++;
        $display("FAIL unexpected_q_valid cyc=%0d q=%h", gcyc, q);
      end else begin
        r = rq.pop_front();
        if (q !== r.d || gcyc != r.due) begin
          miss++;
          $display("FAIL read cyc=%0d got=%h exp=%h due=%0d", gcyc, q, r.d, r.due);
        end
        q_last = r.d;
      end
    end else begin
      vecs++;
      if (q !== q_last) begin
        miss++;
        $display("FAIL q_hold cyc=%0d got=%h exp=%h", gcyc, q, q_last);
      end
    end
    while (rq.size() > 0 && rq[0].due < gcyc) begin
      r = rq.pop_front();
      vecs++; miss++;
      $display("FAIL missing_q_valid due=%0d exp=%h", r.due, r.d);
    end
    if (err === 1'b1) begin
      vecs++;
      if (eq.size() == 0) begin
        miss++;
        $display("FAIL unexpected_err cyc=%0d", gcyc);
      end else begin
        e = eq.pop_front();
        if (e != gcyc) begin
          miss++;
          $display("FAIL err_timing cyc=%0d exp=%0d", gcyc, e);
        end
      end
    end
    while (eq.size() > 0 && eq[0] < gcyc) begin
      e = eq.pop_front();
      vecs++; miss++;
      $display("FAIL missing_err due=%0d", e);
    end
  end

  initial begin
    logic [31:0] a;
    int          k;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 1: hold a read of word 0 through the clear
    repeat (20) apply(1'b1, 1'b0, 32'h0, 32'h0);

    // 2: write/read ordering
    apply(1'b0, 1'b1, 32'h08, 32'hDEADBEEF);
    apply(1'b1, 1'b0, 32'h08, 32'h0);
    apply(1'b1, 1'b0, 32'h08, 32'h0);
    apply(1'b0, 1'b1, 32'h08, 32'h12345678);
    apply(1'b1, 1'b0, 32'h08, 32'h0);

    // 3: streaming writes then back-to-back reads
    for (int i = 0; i < DEPTH; i++) apply(1'b0, 1'b1, 32'(i * 4), 32'(i * 3));
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 1'b0, 32'(i * 4), 32'h0);

    // 4: illegal accesses
    apply(1'b0, 1'b1, 32'h02, 32'hFFFFFFFF);
    apply(1'b1, 1'b0, 32'h00, 32'h0);
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    apply(1'b1, 1'b1, 32'h04, 32'hA5);
    apply(1'b1, 1'b0, 32'h04, 32'h0);
    apply(1'b0, 1'b0, 32'h0, 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 15));
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (k == 0) a = a | 32'($urandom_range(1, 3));
      else if (k == 1) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, $urandom);
    end
    repeat (3) apply(1'b0, 1'b0, 32'h0, 32'h0);

    // 5: reset with a read in flight, then readback after re-clear
    apply(1'b0, 1'b1, 32'h08, 32'hDEADBEEF);
    apply(1'b1, 1'b0, 32'h08, 32'h0);
    do_reset();
    repeat (DEPTH + 1) apply(1'b0, 1'b0, 32'h0, 32'h0);
    apply(1'b1, 1'b0, 32'h08, 32'h0);
    repeat (3) apply(1'b0, 1'b0, 32'h0, 32'h0);

    // 6: reset during the clear, at edge 7
    do_reset();
    while (rel_edge < 6) apply(1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();
    repeat (DEPTH + 2) apply(1'b0, 1'b0, 32'h0, 32'h0);
    apply(1'b1, 1'b0, 32'h3C, 32'h0);
    repeat (6) apply(1'b0, 1'b0, 32'h0, 32'h0);

    @(posedge clk); #1;
    vecs++;
    if (rq.size() != 0 || eq.size() != 0) begin
      miss++;
      $display("FAIL drain pending_reads=%0d pending_errs=%0d exp=0", rq.size(), eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/vector_data_memory.md
# vector_data_memory

Word-organised data memory that services the vector processor's memory port. It sits at the top level opposite `procesador` and connects to its `memAddress`, `memDataInput`, `readEn`, `writeEn` and `dataMem` signals. It accepts single-cycle read/write requests, returns read data after a fixed pipeline latency and flags illegal accesses. After every reset it zero-fills itself before accepting traffic.

## Interface
- `ADDR_WIDTH`, 10: log2 of depth in 32-bit words (DEPTH = 2^ADDR_WIDTH).
- `DATA_WIDTH`, 32: word width.
- `READ_LATENCY`, 2: cycles from read acceptance to `q_valid`; legal range 1..4.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from the processor.
- `data`  in  DATA_WIDTH  write data.
- `rden`  in  1  read request, one cycle per access.
- `wren`  in  1  write request, one cycle per access.
- `q`  out  DATA_WIDTH  read data.
- `q_valid`  out  1  one-cycle pulse; `q` is valid this cycle.
- `ready`  out  1  high when requests are accepted.
- `err`  out  1  one-cycle pulse on a rejected request.

## Operation
- **FSM states:** CLEAR and SERVE.
  - `rst` low forces CLEAR, clear counter = 0 and flushes the read pipeline.
  - CLEAR writes 0 to word `counter` each cycle and increments the counter.
  - When the counter reaches DEPTH-1 and that word is written, the next state is SERVE.
  - SERVE holds until reset.
- **Requests outside SERVE:** `rden`/`wren` while `ready`=0 are ignored silently. No `err`, no `q_valid`.
- **Index and legality:**
  - Word index = `address[ADDR_WIDTH+1:2]`.
  - A request is illegal if `address[1:0]` != 0 or `address[31:ADDR_WIDTH+2]` != 0.
  - An illegal request pulses `err` the next cycle. An illegal write is suppressed. An illegal read produces no `q_valid`.
- **Write:** `wren` accepted in SERVE updates the array at the accepting edge.
- **Read:**
  - `rden` accepted in SERVE samples the array at the accepting edge, before that edge's write.
  - The sampled word travels through a READ_LATENCY-deep valid/data shift pipeline.
  - Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- **Simultaneous `rden` and `wren`:** the write wins and is performed. The read is dropped and `err` pulses.
- **Ordering:** write at cycle N, then read of the same word at N+1, returns the new data. Read at N, then write at N+1, returns the old data.
- **Output hold:** `q` holds its last valid value between pulses. It is reset to 0 only by `rst`.
- **Reset mid-operation:**
  - In-flight reads are discarded (no `q_valid`).
  - A reset during CLEAR restarts the clear from word 0.
  - Array contents after reset are all zero once `ready` rises.

## Timing
- **Reset values:** `q`=0, `q_valid`=0, `ready`=0, `err`=0. All outputs are registered.
- **`ready`:** rises on the DEPTH-th rising edge after `rst` deasserts, counting the first edge after release as edge 1.
- **Read latency:** a read accepted at edge N gives `q_valid`=1 and valid `q` in the cycle following edge N+READ_LATENCY-1. With READ_LATENCY=2 this is two cycles after the request cycle.
- **`err`:** asserted for exactly the cycle after the offending request.
- **Write latency:** written data is visible to a read accepted at the next edge.
- No combinational path from any input to any output.

## Test plan
Benches use ADDR_WIDTH=4 (DEPTH 16) and READ_LATENCY=2.
1. **Reset and clear:** release `rst` and hold `rden`=1 to address 0 throughout. `ready` must rise on edge 16, with no `q_valid` or `err` before that. The first read accepted in SERVE returns 0.
2. **Write/read and ordering:**
   - Write 0xDEADBEEF to 0x08 and read 0x08 next cycle: `q`=0xDEADBEEF with `q_valid` two cycles later.
   - Read 0x08 then write 0x12345678 to it next cycle: `q`=0xDEADBEEF.
3. **Streaming:** write words 0..15 with value index*3, then issue 16 consecutive reads. Expect 16 consecutive `q_valid` pulses with `q`=0,3,…,45 in order.
4. **Illegal accesses:**
   - Write to 0x02: `err` pulses and the word is unchanged.
   - Read 0x40: `err` pulses, no `q_valid`.
   - `rden`+`wren` together to 0x04 with 0xA5: write lands, `err` pulses, no `q_valid`.
5. **Reset mid-flight:** issue a read, then pull `rst` low one cycle later. Expect no `q_valid` and `q`=0. After re-clear, previously written 0xDEADBEEF at 0x08 reads back as 0.
6. **Reset during CLEAR:** assert `rst` at edge 7 of the clear. `ready` must rise exactly 16 edges after the second release.
